// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART receive/echo demo.
package uart_pkg;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // The transmitter walks through the same four phases.
    typedef rx_state_t tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchronizer, arming after a first idle-high sample,
// mid-bit sampling FSM, last-good-byte register and framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 ferr_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   armed_q;
    rx_state_t              state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;

    // Synchronizer chain; resets low so a line held low through reset never looks idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Receive FSM with arming, mid-bit sampling and registered result/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rxs) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (armed_q && !rxs) begin
                        state_q <= START;
                        cnt_q   <= HALF_CNT;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (rxs) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            cnt_q   <= FULL_CNT;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_CNT;
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        if (rxs) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            ferr_q  <= 1'b0;
                        end else begin
                            // Line is still low: disarm so IDLE waits for a high level first.
                            ferr_q  <= 1'b1;
                            armed_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;

endmodule

// File: rtl/uart_rx_led_top.sv
// Board top for the iCE40 UART demo: receiver, status LEDs and optional echo.
// Define UART_ECHO_EN to build the 8N1 echo transmitter; otherwise uarttx idles high.
module uart_rx_led_top
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 hw_clk,
    input  logic                 rst_n,
    input  logic                 uartrx,
    output logic                 uarttx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 led_red,
    output logic                 led_green,
    output logic                 led_blue
);

    logic green_q;

    uart_rx #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk_i   (hw_clk),
        .rst_ni  (rst_n),
        .rx_i    (uartrx),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .ferr_o  (led_red)
    );

    // Green LED flips once per correctly framed byte.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            green_q <= 1'b0;
        end else if (rx_valid) begin
            green_q <= ~green_q;
        end
    end

    assign led_green = green_q;
    assign led_blue  = rx_data[0];

`ifdef UART_ECHO_EN
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_t            tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [IW-1:0]        tx_idx_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_q;

    // Echo serializer; bytes arriving while busy are dropped.
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    if (rx_valid) begin
                        tx_state_q <= START;
                        tx_sh_q    <= rx_data;
                        tx_cnt_q   <= FULL_CNT;
                        tx_q       <= 1'b0;
                    end
                end
                START: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= DATA;
                        tx_idx_q   <= '0;
                        tx_cnt_q   <= FULL_CNT;
                        tx_q       <= tx_sh_q[0];
                        tx_sh_q    <= {1'b1, tx_sh_q[DATA_BITS-1:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= FULL_CNT;
                        if (tx_idx_q == LAST_IDX) begin
                            tx_state_q <= STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= {1'b1, tx_sh_q[DATA_BITS-1:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign uarttx = tx_q;
`else
    assign uarttx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_led_top.sv
`timescale 1ns/1ps
module tb_uart_rx_led_top;

    localparam int CLK_DIV = 104;

    logic       hw_clk;
    logic       rst_n;
    logic       uartrx;
    logic       uarttx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       led_red;
    logic       led_green;
    logic       led_blue;

    uart_rx_led_top #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
        .hw_clk    (hw_clk),
        .rst_n     (rst_n),
        .uartrx    (uartrx),
        .uarttx    (uarttx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue)
    );

    initial hw_clk = 1'b0;
    always #1.25 hw_clk = ~hw_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pulses = 0;
    logic [7:0] exp_q[$];
    bit prev_valid = 1'b0;
    bit tx_low_seen = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        logic [7:0] exp_data;
        bit         exp_red;
        bit         exp_green;
        bit         exp_blue;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uartrx = b;
        repeat (CLK_DIV) @(posedge hw_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap);
        if (stop_ok) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        uartrx = 1'b1;
        repeat (gap) @(posedge hw_clk);
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest byte sent with a good stop bit.
    always @(negedge hw_clk) begin
        if (rx_valid) begin
            n_pulses++;
            if (prev_valid) check("valid_pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_valid = rx_valid;
        if (rst_n && !uarttx) tx_low_seen = 1'b1;
    end

`ifdef UART_ECHO_EN
    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge hw_clk);
            if (rx_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic echo_check(input logic [7:0] d);
        bit seen;
        wait_valid(seen);
        check("echo_valid_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("echo_idle_at_valid", {31'd0, uarttx}, 32'd1);
            @(posedge hw_clk); #1;
            check("echo_start_edge", {31'd0, uarttx}, 32'd0);
            repeat (CLK_DIV / 2) @(posedge hw_clk); #1;
            check("echo_start_mid", {31'd0, uarttx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(posedge hw_clk); #1;
                check($sformatf("echo_bit%0d", i), {31'd0, uarttx}, {31'd0, d[i]});
            end
            repeat (CLK_DIV) @(posedge hw_clk); #1;
            check("echo_stop", {31'd0, uarttx}, 32'd1);
        end
    endtask

    task automatic echo_reset_check();
        bit seen;
        wait_valid(seen);
        check("echo2_valid_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            @(posedge hw_clk);
            repeat (CLK_DIV / 2 + 3 * CLK_DIV) @(posedge hw_clk); #1;
            check("echo2_bit2_low", {31'd0, uarttx}, 32'd0);
            rst_n = 1'b0;
            #0.1;
            check("echo_reset_tx_high", {31'd0, uarttx}, 32'd1);
        end
    endtask
`endif

    initial begin
        tbl[0] = '{8'h55, 1'b1, 2 * CLK_DIV, 8'h55, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{8'hA0, 1'b1, 0,           8'hA0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h01, 1'b1, 2 * CLK_DIV, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 2 * CLK_DIV, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 2 * CLK_DIV, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset with the line held low.
        rst_n  = 1'b0;
        uartrx = 1'b0;
        repeat (5) @(posedge hw_clk);
        #1;
        check("rst_uarttx",   {31'd0, uarttx},    32'd1);
        check("rst_rx_data",  {24'd0, rx_data},   32'd0);
        check("rst_rx_valid", {31'd0, rx_valid},  32'd0);
        check("rst_leds",     {29'd0, led_red, led_green, led_blue}, 32'd0);

        // Low line through and after reset must not produce a frame.
        @(posedge hw_clk);
        rst_n = 1'b1;
        repeat (CLK_DIV) @(posedge hw_clk);
        uartrx = 1'b1;
        repeat (40800) @(posedge hw_clk);
        #1;
        check("arm_no_pulse", n_pulses, 32'd0);
        check("arm_led_red",   {31'd0, led_red},   32'd0);
        check("arm_led_green", {31'd0, led_green}, 32'd0);
        check("arm_tx_idle",   {31'd0, tx_low_seen}, 32'd0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].gap);
            #1;
            check($sformatf("v%0d_rx_data", i), {24'd0, rx_data}, {24'd0, tbl[i].exp_data});
            check($sformatf("v%0d_led_red", i), {31'd0, led_red}, {31'd0, tbl[i].exp_red});
            check($sformatf("v%0d_led_green", i), {31'd0, led_green}, {31'd0, tbl[i].exp_green});
            check($sformatf("v%0d_led_blue", i), {31'd0, led_blue}, {31'd0, tbl[i].exp_blue});
        end
        check("table_pulses", n_pulses, 32'd4);

        // Short low glitch on an idle line.
        @(posedge hw_clk);
        uartrx = 1'b0;
        repeat (40) @(posedge hw_clk);
        uartrx = 1'b1;
        repeat (3 * CLK_DIV) @(posedge hw_clk);
        #1;
        check("glitch_no_pulse", n_pulses, 32'd4);
        check("glitch_led_red", {31'd0, led_red}, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'd0);

        // A real frame right after the glitch is still received.
        send_frame(8'h81, 1'b1, CLK_DIV);
        #1;
        check("post_glitch_data", {24'd0, rx_data}, 32'h81);
        check("tx_idle_no_echo_yet", {31'd0, tx_low_seen}, 32'd0);

`ifdef UART_ECHO_EN
        fork
            send_frame(8'hC3, 1'b1, 3 * CLK_DIV);
            echo_check(8'hC3);
        join
        fork
            send_frame(8'hC3, 1'b1, 6 * CLK_DIV);
            echo_reset_check();
        join
        repeat (3) @(posedge hw_clk);
        #1;
        check("mid_reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge hw_clk);
`else
        check("no_echo_tx_idle", {31'd0, tx_low_seen}, 32'd0);
`endif

        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
